// File: rtl/fir_pkg.sv
// Shared constants, operand types and sign-extension helpers for the polyphase
// FIR bank, its MAC responder (bank_mac) and the decimator top.
package fir_pkg;

  localparam int M           = 20;  // decimation factor, clocks per frame
  localparam int BANK_LEN    = 6;   // coefficients per bank, M >= BANK_LEN+4
  localparam int TAP_WIDTH   = 16;
  localparam int DSP_A_WIDTH = 25;
  localparam int DSP_B_WIDTH = 18;
  localparam int DSP_P_WIDTH = 48;
  localparam int M_LOG2      = $clog2(M);
  localparam int COEF_AW     = $clog2(BANK_LEN);
  localparam int PROD_WIDTH  = DSP_A_WIDTH + DSP_B_WIDTH;

  typedef logic        [M_LOG2-1:0]      phase_t;
  typedef logic        [COEF_AW-1:0]     coef_addr_t;
  typedef logic signed [TAP_WIDTH-1:0]   tap_t;
  typedef logic signed [DSP_A_WIDTH-1:0] dsp_a_t;
  typedef logic signed [DSP_B_WIDTH-1:0] dsp_b_t;
  typedef logic signed [PROD_WIDTH-1:0]  prod_t;
  typedef logic signed [DSP_P_WIDTH-1:0] dsp_p_t;

  // Coefficient onto the multiplier A port, as the bank's operand mux does it.
  function automatic dsp_a_t sext_tap(input tap_t x);
    return {{(DSP_A_WIDTH - TAP_WIDTH){x[TAP_WIDTH-1]}}, x};
  endfunction

  // Full-precision product onto the accumulator width.
  function automatic dsp_p_t sext_prod(input prod_t x);
    return {{(DSP_P_WIDTH - PROD_WIDTH){x[PROD_WIDTH-1]}}, x};
  endfunction

endpackage

// File: rtl/bank_mac_if.sv
// Bank <-> MAC responder signal bundle, including the host coefficient write port.
// The bank/host side uses the master modport, bank_mac uses the slave modport.
interface bank_mac_if;
  import fir_pkg::*;

  logic       clk_2mhz_pos_en;
  phase_t     tap_addr;
  tap_t       tap;
  logic       dsp_acc;
  dsp_a_t     dsp_a;
  dsp_b_t     dsp_b;
  dsp_p_t     dsp_p;
  dsp_p_t     dout;
  logic       dout_valid;
  logic       coef_wr_valid;
  logic       coef_wr_ready;
  coef_addr_t coef_wr_addr;
  tap_t       coef_wr_data;
  logic       overrun;

  modport master (
    output clk_2mhz_pos_en, dsp_a, dsp_b,
    output coef_wr_valid, coef_wr_addr, coef_wr_data,
    input  tap_addr, tap, dsp_acc, dsp_p, dout, dout_valid,
    input  coef_wr_ready, overrun
  );

  modport slave (
    input  clk_2mhz_pos_en, dsp_a, dsp_b,
    input  coef_wr_valid, coef_wr_addr, coef_wr_data,
    output tap_addr, tap, dsp_acc, dsp_p, dout, dout_valid,
    output coef_wr_ready, overrun
  );

endinterface

// File: rtl/dsp_mac.sv
// Three-stage signed multiply-accumulate shaped for a DSP primitive:
// A/B input registers, product register, then the P accumulator.
module dsp_mac
  import fir_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  dsp_a_t a,
  input  dsp_b_t b,
  input  logic   acc,
  output dsp_p_t p
);

  dsp_a_t a_q;
  dsp_b_t b_q;
  prod_t  prod_q;
  logic   acc_d1;
  logic   acc_d2;

  // NOTE: every register here uses <= so all stages sample the previous
  // cycle's values; blocking = would collapse the pipeline into one stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_d1 <= 1'b0;
      prod_q <= '0;
      acc_d2 <= 1'b0;
      p      <= '0;
    end else begin
      a_q    <= a;
      b_q    <= b;
      acc_d1 <= acc;
      // Both operands are signed, so the size casts sign-extend before multiplying.
      prod_q <= PROD_WIDTH'(a_q) * PROD_WIDTH'(b_q);
      acc_d2 <= acc_d1;
      p      <= acc_d2 ? p + sext_prod(prod_q) : sext_prod(prod_q);
    end
  end

endmodule

// File: rtl/bank_mac.sv
// Per-bank MAC responder: sequences tap_addr over each frame, serves coefficients
// from a host-loaded memory, runs the shared MAC and captures the frame sum.
module bank_mac
  import fir_pkg::*;
(
  input logic       clk,
  input logic       rst_n,
  bank_mac_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam phase_t LAST_PHASE    = phase_t'(M - 1);
  localparam phase_t END_PHASE     = phase_t'(M - 2);
  localparam phase_t CAPTURE_PHASE = phase_t'(BANK_LEN + 2);

  logic [0:0] state_q;
  logic [0:0] state_d;
  phase_t     tap_addr_q;
  phase_t     tap_addr_d;
  logic       dsp_acc_q;
  logic       ready_q;
  logic       overrun_q;
  tap_t       coef_q [BANK_LEN];
  tap_t       tap;
  logic       wr_fire;
  logic       capture;
  dsp_p_t     p;
  dsp_p_t     dout_q;
  logic       dout_valid_q;

  // IDLE parks on M-1 rather than 0: the bank shifts its delay line at phase 0.
  // RUN hands back to IDLE as the counter reaches M-1, so a strobe landing on
  // that last phase starts the next frame without an overrun.
  // NOTE: defaults before the case keep every path assigned, so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    tap_addr_d = tap_addr_q;
    case (state_q)
      IDLE: begin
        if (bus.clk_2mhz_pos_en) begin
          state_d    = RUN;
          tap_addr_d = '0;
        end
      end
      RUN: begin
        tap_addr_d = tap_addr_q + phase_t'(1);
        if (tap_addr_q == END_PHASE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // dsp_acc and coef_wr_ready are registered so both read 0 while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tap_addr_q <= LAST_PHASE;
      dsp_acc_q  <= 1'b0;
      ready_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tap_addr_q <= tap_addr_d;
      dsp_acc_q  <= (tap_addr_d != '0);
      ready_q    <= (state_d == IDLE);
      if (state_q == RUN && bus.clk_2mhz_pos_en) overrun_q <= 1'b1;
    end
  end

  // Out-of-range addresses still complete the handshake but write nothing.
  assign wr_fire = bus.coef_wr_valid && ready_q && (int'(bus.coef_wr_addr) < BANK_LEN);

  // NOTE: the coefficient array is small and must read as zero after reset,
  // so it sits in flops with the async clear instead of a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BANK_LEN; i++) coef_q[i] <= '0;
    end else if (wr_fire) begin
      coef_q[bus.coef_wr_addr] <= bus.coef_wr_data;
    end
  end

  always_comb begin
    tap = '0;
    if (int'(tap_addr_q) < BANK_LEN) tap = coef_q[tap_addr_q[COEF_AW-1:0]];
  end

  dsp_mac u_dsp_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (bus.dsp_a),
    .b     (bus.dsp_b),
    .acc   (dsp_acc_q),
    .p     (p)
  );

  // The last real product lands on P at phase BANK_LEN+2 of the frame.
  assign capture = (state_q == RUN) && (tap_addr_q == CAPTURE_PHASE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_valid_q <= capture;
      if (capture) dout_q <= p;
    end
  end

  assign bus.tap_addr      = tap_addr_q;
  assign bus.tap           = tap;
  assign bus.dsp_acc       = dsp_acc_q;
  assign bus.dsp_p         = p;
  assign bus.dout          = dout_q;
  assign bus.dout_valid    = dout_valid_q;
  assign bus.coef_wr_ready = ready_q;
  assign bus.overrun       = overrun_q;

endmodule

// File: tb/tb_bank_mac.sv
// Self-checking bench for bank_mac: directed frames plus randomized frames,
// each checked against a dot-product model of the bank's coefficients and operands.
module tb_bank_mac;
  import fir_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bank_mac_if bus ();

  bank_mac u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  tap_t   coef_m [BANK_LEN];
  dsp_a_t op_a   [BANK_LEN];
  dsp_b_t op_b   [BANK_LEN];
  bit     use_tap;
  bit     ovr_m;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
    end
  endtask

  // Bank model: drives operands for valid taps, zero elsewhere.
  initial begin
    bus.dsp_a = '0;
    bus.dsp_b = '0;
    forever begin
      @(negedge clk);
      if (int'(bus.tap_addr) < BANK_LEN) begin
        bus.dsp_a = use_tap ? sext_tap(bus.tap) : op_a[int'(bus.tap_addr)];
        bus.dsp_b = op_b[int'(bus.tap_addr)];
      end else begin
        bus.dsp_a = '0;
        bus.dsp_b = '0;
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

  function automatic dsp_p_t frame_sum();
    longint s = 0;
    for (int k = 0; k < BANK_LEN; k++)
      s += (use_tap ? longint'(coef_m[k]) : longint'(op_a[k])) * longint'(op_b[k]);
    return dsp_p_t'(s);
  endfunction

  // Called just after a negedge; holds valid until the handshake completes.
  task automatic write_coef(input int addr, input tap_t data);
    int n = 0;
    bus.coef_wr_valid = 1'b1;
    bus.coef_wr_addr  = coef_addr_t'(addr);
    bus.coef_wr_data  = data;
    while (!bus.coef_wr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("wr_ready", 64'(bus.coef_wr_ready), 64'(1));
    @(negedge clk);
    bus.coef_wr_valid = 1'b0;
    if (n < 50 && addr < BANK_LEN) coef_m[addr] = data;
  endtask

  task automatic set_b(input dsp_b_t b);
    for (int k = 0; k < BANK_LEN; k++) op_b[k] = b;
  endtask

  // One frame, cycle by cycle from t0. start=0 continues a chained frame.
  task automatic run_frame(input string tag, input bit start, input bit mid_strobe,
                           input bit chain, input bit wr_in_run);
    dsp_p_t exp = frame_sum();
    if (start) begin
      bus.clk_2mhz_pos_en = 1'b1;
      @(negedge clk);
      bus.clk_2mhz_pos_en = 1'b0;
    end
    for (int c = 0; c < M; c++) begin
      check({tag, " tap_addr"}, 64'(bus.tap_addr), 64'(c));
      check({tag, " dsp_acc"}, 64'(bus.dsp_acc), 64'(c != 0));
      if (c < BANK_LEN) check({tag, " tap"}, 64'(bus.tap), 64'(coef_m[c]));
      check({tag, " dout_valid"}, 64'(bus.dout_valid), 64'(c == BANK_LEN + 3));
      if (c == BANK_LEN + 2) check({tag, " dsp_p"}, 64'(bus.dsp_p), 64'(exp));
      if (c == BANK_LEN + 3) check({tag, " dout"}, 64'(bus.dout), 64'(exp));
      if (wr_in_run && c == 3) begin
        bus.coef_wr_valid = 1'b1;
        bus.coef_wr_addr  = coef_addr_t'(2);
        bus.coef_wr_data  = 16'sh7FFF;
      end
      if (wr_in_run && c >= 3)
        check({tag, " wr_ready"}, 64'(bus.coef_wr_ready), 64'(c == M - 1));
      bus.clk_2mhz_pos_en = (mid_strobe && c == 7) || (chain && c == M - 1);
      @(negedge clk);
      bus.clk_2mhz_pos_en = 1'b0;
      if (wr_in_run && c == M - 1) begin
        bus.coef_wr_valid = 1'b0;
        coef_m[2] = 16'sh7FFF;
      end
    end
    check({tag, " overrun"}, 64'(bus.overrun), 64'(ovr_m));
  endtask

  initial begin
    rst_n               = 1'b0;
    bus.clk_2mhz_pos_en = 1'b0;
    bus.coef_wr_valid   = 1'b0;
    bus.coef_wr_addr    = '0;
    bus.coef_wr_data    = '0;
    use_tap             = 1'b1;
    ovr_m               = 1'b0;
    for (int k = 0; k < BANK_LEN; k++) begin
      coef_m[k] = '0;
      op_a[k]   = '0;
      op_b[k]   = '0;
    end

    repeat (2) @(negedge clk);
    check("rst tap_addr", 64'(bus.tap_addr), 64'(M - 1));
    check("rst tap", 64'(bus.tap), 64'(0));
    check("rst dsp_acc", 64'(bus.dsp_acc), 64'(0));
    check("rst dsp_p", 64'(bus.dsp_p), 64'(0));
    check("rst dout", 64'(bus.dout), 64'(0));
    check("rst dout_valid", 64'(bus.dout_valid), 64'(0));
    check("rst overrun", 64'(bus.overrun), 64'(0));
    check("rst wr_ready", 64'(bus.coef_wr_ready), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("idle wr_ready", 64'(bus.coef_wr_ready), 64'(1));

    // Unit coefficients, b=3: 6 * 1 * 3
    for (int k = 0; k < BANK_LEN; k++) write_coef(k, 16'sd1);
    set_b(18'sd3);
    run_frame("t1", 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) begin
      check("t1 hold", 64'(bus.tap_addr), 64'(M - 1));
      @(negedge clk);
    end

    // Ramp coefficients, back-to-back strobe on the last phase
    for (int k = 0; k < BANK_LEN; k++) write_coef(k, tap_t'(k + 1));
    set_b(18'sd10);
    run_frame("t2a", 1'b1, 1'b0, 1'b1, 1'b0);
    run_frame("t2b", 1'b0, 1'b0, 1'b0, 1'b0);

    // Negative operands, result must stay positive through the 48-bit sign extension
    for (int k = 0; k < BANK_LEN; k++) write_coef(k, -16'sd1);
    set_b(-18'sd2048);
    run_frame("t3", 1'b1, 1'b0, 1'b0, 1'b0);
    check("t3 dsp_p_hi", 64'(bus.dsp_p[47:24]), 64'(0));
    check("t3 dout_val", 64'(bus.dout), 64'(12288));

    // Strobe mid-frame is ignored but sticks in overrun
    ovr_m = 1'b1;
    run_frame("t4", 1'b1, 1'b1, 1'b0, 1'b0);
    run_frame("t4b", 1'b1, 1'b0, 1'b0, 1'b0);

    // Write held off during RUN, lands on the first IDLE phase
    set_b(18'sd1);
    run_frame("t5", 1'b1, 1'b0, 1'b0, 1'b1);
    write_coef(6, 16'sh1234);
    run_frame("t5b", 1'b1, 1'b0, 1'b0, 1'b0);

    // Randomized coefficients and operands
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < BANK_LEN; k++) write_coef(k, tap_t'($urandom));
      write_coef(int'($urandom_range(BANK_LEN, (1 << COEF_AW) - 1)), tap_t'($urandom));
      use_tap = bit'($urandom_range(0, 1));
      for (int k = 0; k < BANK_LEN; k++) begin
        op_a[k] = dsp_a_t'($urandom);
        op_b[k] = dsp_b_t'($urandom);
      end
      run_frame($sformatf("rnd%0d", r), 1'b1, 1'b0, 1'b0, 1'b0);
    end

    // Reset in the middle of a frame
    use_tap = 1'b1;
    set_b(18'sd5);
    for (int k = 0; k < BANK_LEN; k++) write_coef(k, tap_t'(k + 2));
    bus.clk_2mhz_pos_en = 1'b1;
    @(negedge clk);
    bus.clk_2mhz_pos_en = 1'b0;
    repeat (3) @(negedge clk);
    check("t6 pre tap_addr", 64'(bus.tap_addr), 64'(3));
    rst_n = 1'b0;
    #1;
    check("t6 tap_addr", 64'(bus.tap_addr), 64'(M - 1));
    check("t6 tap", 64'(bus.tap), 64'(0));
    check("t6 dsp_acc", 64'(bus.dsp_acc), 64'(0));
    check("t6 dsp_p", 64'(bus.dsp_p), 64'(0));
    check("t6 dout", 64'(bus.dout), 64'(0));
    check("t6 dout_valid", 64'(bus.dout_valid), 64'(0));
    check("t6 overrun", 64'(bus.overrun), 64'(0));
    check("t6 wr_ready", 64'(bus.coef_wr_ready), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    ovr_m = 1'b0;
    for (int k = 0; k < BANK_LEN; k++) coef_m[k] = '0;
    repeat (14) begin
      @(negedge clk);
      check("t6 no_valid", 64'(bus.dout_valid), 64'(0));
      check("t6 idle addr", 64'(bus.tap_addr), 64'(M - 1));
    end
    run_frame("t6 cleared", 1'b1, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bank_mac.md
Name: bank_mac

Overview:
- Responder and sequencer end of the polyphase FIR bank's shared-DSP interface.
- Generates the per-frame `tap_addr` sequence, the coefficient `tap`, and `dsp_acc` for one bank.
- Consumes the bank's `dsp_a`/`dsp_b` operands and performs the pipelined multiply-accumulate, returning `dsp_p`.
- Holds the bank's coefficient memory, which host logic loads through a ready/valid write port. One instance sits beside each bank inside the polyphase decimator.

Parameters:
- M, 20, decimation factor; clock cycles per frame.
- BANK_LEN, 6, coefficients per bank; requires M >= BANK_LEN+4.
- TAP_WIDTH, 16, coefficient width (signed).
- DSP_A_WIDTH, 25, multiplier A operand width.
- DSP_B_WIDTH, 18, multiplier B operand width.
- DSP_P_WIDTH, 48, accumulator width.
- M_LOG2, $clog2(M), tap_addr width (derived).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- clk_2mhz_pos_en  in  1  frame-start strobe, one clk wide.
- tap_addr  out  M_LOG2  phase counter to the bank.
- tap  out  TAP_WIDTH  coefficient for the current tap_addr.
- dsp_acc  out  1  0 = load, 1 = accumulate (to bank operand mux).
- dsp_a  in  DSP_A_WIDTH  signed multiplicand from the bank.
- dsp_b  in  DSP_B_WIDTH  signed multiplier from the bank.
- dsp_p  out  DSP_P_WIDTH  accumulator (P register).
- dout  out  DSP_P_WIDTH  captured frame sum.
- dout_valid  out  1  one-cycle pulse when dout updates.
- coef_wr_valid  in  1  coefficient write request.
- coef_wr_ready  out  1  write accepted when high with valid.
- coef_wr_addr  in  $clog2(BANK_LEN)  coefficient index.
- coef_wr_data  in  TAP_WIDTH  signed coefficient.
- overrun  out  1  sticky: strobe arrived during RUN.

Behaviour:

Reset:
- All outputs take these values: tap_addr=M-1, tap=0, dsp_acc=0, dsp_p=0, dout=0, dout_valid=0, overrun=0, coef_wr_ready=0 during reset.
- Pipeline registers and coefficients clear to 0.

FSM states IDLE and RUN:
- IDLE: tap_addr holds M-1, never 0, because the bank shifts its delay line when tap_addr is 0. coef_wr_ready=1.
- IDLE to RUN on clk_2mhz_pos_en. tap_addr=0 in the next cycle (t0).
- RUN: tap_addr increments by 1 per clk. After M-1, return to IDLE, with tap_addr remaining M-1.
- clk_2mhz_pos_en in RUN: ignored, and overrun is set. It clears only on reset.
- Strobe in the same cycle RUN ends (tap_addr=M-1): treated as IDLE, so the next frame starts immediately at tap_addr=0.

Outputs to the bank:
- tap = coef[tap_addr] when tap_addr < BANK_LEN, else 0. It is combinational from tap_addr and the registered coefficient memory.
- dsp_acc = 0 when tap_addr == 0, else 1.

MAC pipeline (3 stages):
- A/B input registers, then product register (DSP_A_WIDTH+DSP_B_WIDTH bits, signed), then P.
- The acc flag is delayed 2 cycles alongside the operands.
- P <= acc_d2 ? P + sext(prod) : sext(prod).
- Two's-complement wrap at DSP_P_WIDTH, no saturation.
- The pipeline runs every cycle, including IDLE. Operands are zero outside the valid taps, so P is unchanged except by real products.

Result capture:
- The final sum appears on dsp_p in cycle t0+BANK_LEN+2.
- dout registers it and dout_valid pulses in cycle t0+BANK_LEN+3. dout holds until the next capture.

Coefficient writes:
- A write is accepted when coef_wr_valid && coef_wr_ready; memory updates at that edge.
- Writes are never accepted in RUN, where coef_wr_ready=0.
- Out-of-range coef_wr_addr (>= BANK_LEN) is handshaken and discarded.

Reset mid-frame:
- Asynchronously returns to IDLE with tap_addr=M-1.
- No dout_valid for the aborted frame. Coefficients are cleared.

Decomposition:
- Shared package (fir_pkg) holds M, BANK_LEN, TAP_WIDTH, DSP_*_WIDTH, and the sign-extension functions, all shared with the bank and the decimator top.
- Sub-module dsp_mac: 3-stage signed MAC (clk, rst_n, a, b, acc, p), to map onto the DSP primitive.
- The FSM and coefficient memory stay in bank_mac.

Test Plan:
1. Load coef 0..5 = 1. Strobe. Drive dsp_a=tap, and dsp_b=3 when tap_addr<6, else 0. Required: dout=18, dout_valid pulse at t0+9, tap_addr sequence 0..19 then held at 19.
2. Load coef k = k+1, dsp_b=10 on valid taps. Required: dout=210. Back-to-back strobe exactly at tap_addr=19 gives tap_addr=0 next cycle and a second dout=210, with overrun=0.
3. Load coef = -1, dsp_b=-2048. Required: dout=12288. Two's-complement sign extension is checked on dsp_p bits 47..24 (all zero).
4. Strobe at tap_addr=7 mid-RUN. Required: ignored, frame completes unchanged, overrun=1 and stays 1.
5. Assert coef_wr_valid during RUN with addr 2, data 0x7FFF. Required: coef_wr_ready=0, no write, and the write completes in the first IDLE cycle. addr 6 is accepted with memory unchanged.
6. Assert rst_n=0 at tap_addr=3. Required: outputs reach reset values immediately, no dout_valid, and tap_addr=19 after release.
